// File: rtl/mux_pkg.sv
// mux_pkg: shared radix, mode type and tree-depth helper for the pipelined mux tree.
package mux_pkg;
    localparam int MUX_RADIX = 4;
    typedef enum logic {MODE_DIRECT, MODE_SCAN} mux_mode_e;
    function automatic int clog4(input int n);
        int l = 1;
        for (int p = MUX_RADIX; p < n; p *= MUX_RADIX) l++;
        return l;
    endfunction
endpackage

// File: rtl/mux4_stage.sv
// mux4_stage: one registered 4-to-1 node of the mux tree.
module mux4_stage
    import mux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MUX_RADIX*W-1:0] d,
    input  logic [1:0]           sel,
    output logic [W-1:0]         q
);
    always_ff @(posedge clk) q <= rst ? '0 : d[sel*W +: W];
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N-to-1 mux tree (one level per stage) with direct/scan selection
// and an aligned valid/channel/error sideband.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int N  = 10,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    output logic [SW-1:0] out_ch,
    output logic          out_err
);
    localparam int LV = clog4(N);
    localparam int IW = 2 * LV;
    localparam int FL = (MUX_RADIX**LV - 1) / 3;
    localparam int NT = FL + MUX_RADIX**LV;

    logic [SW-1:0] scan_cnt, idx;
    logic [W-1:0]  tree [NT];
    logic [1:0]    lsel [LV];
    logic [LV-1:0] v_q, e_q;
    logic [SW-1:0] ch_q [LV];

    assign idx = (mux_mode_e'(mode) == MODE_SCAN) ? scan_cnt : sel;

    always_ff @(posedge clk) begin
        if (rst) scan_cnt <= '0;
        else if (in_valid && mode) scan_cnt <= (scan_cnt == SW'(N - 1)) ? '0 : scan_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            e_q <= '0;
            for (int i = 0; i < LV; i++) ch_q[i] <= '0;
        end else begin
            v_q[0]  <= in_valid;
            e_q[0]  <= in_valid && (32'(idx) >= N);
            ch_q[0] <= in_valid ? idx : '0;
            for (int i = 1; i < LV; i++) begin
                v_q[i]  <= v_q[i-1];
                e_q[i]  <= e_q[i-1];
                ch_q[i] <= ch_q[i-1];
            end
        end
    end

    // Level j steers with bits [2j+1:2j] of the index of the entry it is currently holding.
    for (genvar j = 0; j < LV; j++) begin : g_sel
        if (j == 0) begin : g_l0
            assign lsel[j] = 2'(IW'(idx));
        end else begin : g_ln
            assign lsel[j] = 2'(IW'(ch_q[j-1]) >> (2 * j));
        end
    end

    // Heap layout: node n has children 4n+1..4n+4; leaves past N (and bubbles) are zero.
    for (genvar k = 0; k < MUX_RADIX**LV; k++) begin : g_leaf
        if (k < N) begin : g_ch
            assign tree[FL+k] = in_valid ? data[k*W +: W] : '0;
        end else begin : g_pad
            assign tree[FL+k] = '0;
        end
    end

    for (genvar d = 0; d < LV; d++) begin : g_lvl
        for (genvar k = 0; k < MUX_RADIX**d; k++) begin : g_node
            localparam int NI = (MUX_RADIX**d - 1) / 3 + k;
            mux4_stage #(.W(W)) u_stage (
                .clk(clk),
                .rst(rst),
                .d({tree[4*NI+4], tree[4*NI+3], tree[4*NI+2], tree[4*NI+1]}),
                .sel(lsel[LV-1-d]),
                .q(tree[NI])
            );
        end
    end

    assign out_data  = tree[0];
    assign out_valid = v_q[LV-1];
    assign out_ch    = ch_q[LV-1];
    assign out_err   = e_q[LV-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: four configurations driven from shared stimulus, each checked every cycle
// against a queue-based latency model, plus literal expectations on the N=10, W=8 instance.
module tb_mux_tree_pipe;
    import mux_pkg::*;

    localparam int NC = 4;
    localparam int NS [NC] = '{10, 4, 16, 64};
    localparam int WS [NC] = '{8, 8, 8, 1};

    logic         clk = 0, rst = 1, in_valid = 0, mode = 0;
    logic [5:0]   sel_raw = '0;
    logic [511:0] data_raw = '0;
    bit           chk_en = 0;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    for (genvar c = 0; c < NC; c++) begin : g_cfg
        localparam int N = NS[c], W = WS[c], SW = $clog2(N), LV = clog4(N);
        logic [SW-1:0]  sel, out_ch;
        logic [N*W-1:0] data;
        logic [W-1:0]   out_data;
        logic           out_valid, out_err;
        assign sel  = sel_raw[SW-1:0];
        assign data = data_raw[N*W-1:0];

        mux_tree_pipe #(.N(N), .W(W)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .sel(sel), .data(data),
            .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch), .out_err(out_err)
        );

        // Queue of entries in flight; element 0 is what the output must show.
        int cnt = 0;
        bit qv[$], qe[$];
        int qc[$];
        logic [W-1:0] qd[$];

        initial for (int i = 0; i < LV; i++) begin
            qv.push_back(0); qe.push_back(0); qc.push_back(0); qd.push_back('0);
        end

        always @(posedge clk) begin
            int idx;
            bit v;
            if (rst) begin
                cnt = 0;
                for (int i = 0; i < LV; i++) begin
                    qv[i] = 0; qe[i] = 0; qc[i] = 0; qd[i] = '0;
                end
            end else begin
                v   = in_valid;
                idx = mode ? cnt : int'(sel);
                qv.push_back(v);
                qc.push_back(v ? idx : 0);
                qe.push_back(v && idx >= N);
                qd.push_back((v && idx < N) ? data[idx*W +: W] : '0);
                void'(qv.pop_front()); void'(qc.pop_front());
                void'(qe.pop_front()); void'(qd.pop_front());
                if (v && mode) cnt = (cnt + 1) % N;
            end
        end

        always @(negedge clk) if (chk_en) begin
            check($sformatf("n%0d_valid", N), 64'(out_valid), 64'(qv[0]));
            check($sformatf("n%0d_ch", N), 64'(out_ch), 64'(qc[0]));
            check($sformatf("n%0d_err", N), 64'(out_err), 64'(qe[0]));
            check($sformatf("n%0d_data", N), 64'(out_data), 64'(qd[0]));
        end
    end

    initial begin
        int seen_ch[$];
        logic [7:0] seen_d[$];
        int gap, pend;
        bit vpat[19];
        bit md[6];
        int exp5[6];
        int oor[2];
        oor  = '{12, 15};
        md   = '{1, 1, 0, 0, 1, 1};
        exp5 = '{2, 3, 7, 7, 4, 5};
        for (int k = 0; k < 64; k++) data_raw[k*8 +: 8] = 8'(8'hA0 + k);

        // reset held with in_valid=1
        rst = 1; in_valid = 1; mode = 0; sel_raw = 6'd3;
        repeat (3) begin
            @(negedge clk);
            chk_en = 1;
            check("rst_valid", 64'(g_cfg[0].out_valid), 64'd0);
            check("rst_data", 64'(g_cfg[0].out_data), 64'd0);
            check("rst_ch", 64'(g_cfg[0].out_ch), 64'd0);
            check("rst_err", 64'(g_cfg[0].out_err), 64'd0);
        end
        rst = 0; in_valid = 0;
        @(negedge clk);
        check("post_rst_valid", 64'(g_cfg[0].out_valid), 64'd0);
        check("post_rst_data", 64'(g_cfg[0].out_data), 64'd0);
        check("scan_cnt_rst", 64'(g_cfg[0].dut.scan_cnt), 64'd0);

        // direct mode, sel 0..9 back to back
        mode = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10);
            sel_raw = 6'(i);
            @(negedge clk);
            if (i >= 1 && i <= 10) begin
                check("t2_valid", 64'(g_cfg[0].out_valid), 64'd1);
                check("t2_data", 64'(g_cfg[0].out_data), 64'(8'hA0 + i - 1));
                check("t2_ch", 64'(g_cfg[0].out_ch), 64'(i - 1));
                check("t2_err", 64'(g_cfg[0].out_err), 64'd0);
            end
        end

        // out-of-range select
        for (int i = 0; i < 3; i++) begin
            in_valid = (i < 2);
            sel_raw = (i < 2) ? 6'(oor[i]) : 6'd0;
            @(negedge clk);
            if (i >= 1) begin
                check("oor_valid", 64'(g_cfg[0].out_valid), 64'd1);
                check("oor_err", 64'(g_cfg[0].out_err), 64'd1);
                check("oor_data", 64'(g_cfg[0].out_data), 64'd0);
                check("oor_ch", 64'(g_cfg[0].out_ch), 64'(oor[i-1]));
            end
        end
        in_valid = 0;
        repeat (2) @(negedge clk);

        // scan mode: 5 valid, 3-cycle bubble, 7 valid, then flush
        for (int i = 0; i < 19; i++) vpat[i] = (i < 5) || (i >= 8 && i < 15);
        mode = 1; gap = 0; pend = 0;
        for (int i = 0; i < 19; i++) begin
            in_valid = vpat[i];
            sel_raw = 6'($urandom_range(0, 63));
            @(negedge clk);
            if (g_cfg[0].out_valid) begin
                if (seen_ch.size() > 0) gap += pend;
                pend = 0;
                seen_ch.push_back(int'(g_cfg[0].out_ch));
                seen_d.push_back(g_cfg[0].out_data);
            end else if (seen_ch.size() > 0) pend++;
        end
        check("scan_count", 64'(seen_ch.size()), 64'd12);
        check("scan_gap", 64'(gap), 64'd3);
        for (int k = 0; k < 12 && k < seen_ch.size(); k++) begin
            check("scan_ch", 64'(seen_ch[k]), 64'(k % 10));
            check("scan_data", 64'(seen_d[k]), 64'(8'hA0 + k % 10));
        end

        // mode switching: scan 2,3 -> direct 7,7 -> scan 4,5
        seen_ch.delete();
        sel_raw = 6'd7;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 6);
            mode = (i < 6) ? md[i] : 1'b0;
            @(negedge clk);
            if (g_cfg[0].out_valid) seen_ch.push_back(int'(g_cfg[0].out_ch));
        end
        check("sw_count", 64'(seen_ch.size()), 64'd6);
        for (int k = 0; k < 6 && k < seen_ch.size(); k++) check("sw_ch", 64'(seen_ch[k]), 64'(exp5[k]));

        // reset with entries in flight, rst coincident with a valid
        mode = 0; in_valid = 1; sel_raw = 6'd1;
        @(negedge clk);
        check("mid_valid", 64'(g_cfg[0].out_valid), 64'd0);
        rst = 1; sel_raw = 6'd2;
        @(negedge clk);
        check("mid_valid", 64'(g_cfg[0].out_valid), 64'd0);
        rst = 0; in_valid = 0;
        repeat (3) begin
            @(negedge clk);
            check("mid_valid", 64'(g_cfg[0].out_valid), 64'd0);
        end
        in_valid = 1; sel_raw = 6'd3;
        @(negedge clk);
        check("first_valid_early", 64'(g_cfg[0].out_valid), 64'd0);
        in_valid = 0;
        @(negedge clk);
        check("first_valid", 64'(g_cfg[0].out_valid), 64'd1);
        check("first_ch", 64'(g_cfg[0].out_ch), 64'd3);
        check("first_data", 64'(g_cfg[0].out_data), 64'h00A3);

        // sweep every channel in direct mode with random data
        for (int w = 0; w < 16; w++) data_raw[w*32 +: 32] = $urandom();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1; mode = 0; sel_raw = 6'(i);
            @(negedge clk);
        end

        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom_range(0, 1));
            sel_raw = 6'($urandom_range(0, 63));
            rst = ($urandom_range(0, 39) == 0);
            for (int w = 0; w < 16; w++) data_raw[w*32 +: 32] = $urandom();
            @(negedge clk);
        end
        rst = 0; in_valid = 0;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
